// File: rtl/uart_pkg.sv
// Shared definitions for the command-byte UART transmitter: FSM encoding,
// frame geometry and the bit-period derivation.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam int TIMER_W   = 16;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_cmd_tx_if.sv
// Command-byte input and serial-line outputs of the transmitter.
interface uart_cmd_tx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] data_in;
   logic                 tx;
   logic                 busy;
   logic                 overflow;

   modport master (output data_in, input tx, input busy, input overflow);
   modport slave  (input data_in, output tx, output busy, output overflow);

endinterface

// File: rtl/uart_cmd_fifo.sv
// Small synchronous command FIFO; head is visible combinationally so the
// transmitter can load it on the same edge it pops. Overflow is sticky.
module uart_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             overflow_reg;
   logic             push_ok;
   logic             pop_ok;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // A simultaneous pop frees the slot the push writes into, so full only blocks a lone push.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   assign dout     = mem[rd_ptr_reg[AW-1:0]];
   assign overflow = overflow_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !push_ok) begin
            overflow_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_tx.sv
// Change-detecting command queue feeding a UART transmitter (8N1, LSB first).
// Define UART_TX_PARITY_EN for an even parity bit (8E1).
module uart_cmd_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_cmd_tx_if.slave  bus
);

   localparam int                 CPB         = clks_per_bit(CLK_FREQ, BAUD);
   localparam int                 CNT_W       = $clog2(DATA_BITS);
   localparam logic [TIMER_W-1:0] BIT_RELOAD  = TIMER_W'(CPB - 1);
   localparam logic [TIMER_W-1:0] STOP_RELOAD = TIMER_W'(CPB * STOP_BITS - 1);
   localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_BITS - 1);

   tx_state_t            state_reg;
   logic [TIMER_W-1:0]   timer_reg;
   logic [CNT_W-1:0]     bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_data_reg;
   logic [DATA_BITS-1:0] last_seen_reg;
   logic                 tx_reg;
`ifdef UART_TX_PARITY_EN
   logic                 parity_reg;
`endif

   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_overflow;

   assign push = (bus.data_in != last_seen_reg);

   // Popping at the end of STOP chains frames with no idle gap.
   assign pop = !fifo_empty &&
                ((state_reg == ST_IDLE) ||
                 ((state_reg == ST_STOP) && (timer_reg == '0)));

   uart_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .din      (bus.data_in),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (fifo_overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         timer_reg      <= '0;
         bit_cnt_reg    <= '0;
         shift_data_reg <= '0;
         last_seen_reg  <= '0;
         tx_reg         <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_reg     <= 1'b0;
`endif
      end else begin
         if (push) begin
            last_seen_reg <= bus.data_in;
         end

         case (state_reg)
            ST_IDLE: begin
               tx_reg <= 1'b1;
            end
            ST_START: begin
               if (timer_reg == '0) begin
                  state_reg <= ST_DATA;
                  tx_reg    <= shift_data_reg[0];
                  timer_reg <= BIT_RELOAD;
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
            ST_DATA: begin
               if (timer_reg == '0) begin
                  if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     state_reg <= ST_PARITY;
                     tx_reg    <= parity_reg;
                     timer_reg <= BIT_RELOAD;
`else
                     state_reg <= ST_STOP;
                     tx_reg    <= 1'b1;
                     timer_reg <= STOP_RELOAD;
`endif
                  end else begin
                     shift_data_reg <= shift_data_reg >> 1;
                     tx_reg         <= shift_data_reg[1];
                     bit_cnt_reg    <= bit_cnt_reg + 1'b1;
                     timer_reg      <= BIT_RELOAD;
                  end
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (timer_reg == '0) begin
                  state_reg <= ST_STOP;
                  tx_reg    <= 1'b1;
                  timer_reg <= STOP_RELOAD;
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (timer_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               tx_reg    <= 1'b1;
            end
         endcase

         // Loading a new frame takes priority over the IDLE/STOP updates above.
         if (pop) begin
            state_reg      <= ST_START;
            tx_reg         <= 1'b0;
            shift_data_reg <= fifo_dout;
            bit_cnt_reg    <= '0;
            timer_reg      <= BIT_RELOAD;
`ifdef UART_TX_PARITY_EN
            parity_reg     <= ^fifo_dout;
`endif
         end
      end
   end

   assign bus.tx       = tx_reg;
   assign bus.busy     = (state_reg != ST_IDLE) || !fifo_empty;
   assign bus.overflow = fifo_overflow;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule
